// File: rtl/rv_pkg.sv
// Shared types and constants for the byte-stream bus master: FSM state
// encoding, command bytes and a width helper.
package rv_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RX_DATA = 3'd1,
        WR_REQ  = 3'd2,
        RD_REQ  = 3'd3,
        TX_DATA = 3'd4
    } state_e;

    localparam logic [7:0] CMD_READ  = 8'h00;
    localparam logic [7:0] CMD_WRITE = 8'h01;

    function automatic int max_width(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rv_bus_master_if.sv
// Byte-stream command port, response port and register-device port of the
// bus master. The master modport is the block's view, slave is the environment's.
interface rv_bus_master_if #(
    parameter int WRITE_WIDTH = 32,
    parameter int READ_WIDTH  = 32
);
    logic                   RX_VALID_I;
    logic [7:0]             RX_DATA_I;
    logic                   RX_READY_O;
    logic                   TX_VALID_O;
    logic [7:0]             TX_DATA_O;
    logic                   TX_READY_I;
    logic                   READ_READY_O;
    logic                   READ_VALID_I;
    logic [READ_WIDTH-1:0]  READ_DATA_I;
    logic                   WRITE_VALID_O;
    logic [WRITE_WIDTH-1:0] WRITE_DATA_O;
    logic                   WRITE_READY_I;
    logic                   ERROR_O;

    modport master (
        input  RX_VALID_I, RX_DATA_I, TX_READY_I, READ_VALID_I, READ_DATA_I, WRITE_READY_I,
        output RX_READY_O, TX_VALID_O, TX_DATA_O, READ_READY_O, WRITE_VALID_O, WRITE_DATA_O,
               ERROR_O
    );

    modport slave (
        output RX_VALID_I, RX_DATA_I, TX_READY_I, READ_VALID_I, READ_DATA_I, WRITE_READY_I,
        input  RX_READY_O, TX_VALID_O, TX_DATA_O, READ_READY_O, WRITE_VALID_O, WRITE_DATA_O,
               ERROR_O
    );

endinterface

// File: rtl/rv_byte_shifter.sv
// Byte-wide right shifter with parallel load. Shifting inserts the new byte at
// the MSB end, so it both assembles LSB-first input and serialises from bit 0.
module rv_byte_shifter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             shift_i,
    input  logic [7:0]       shift_byte_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] shifted;

    if (WIDTH > 8) begin : g_wide
        assign shifted = {shift_byte_i, data_q[WIDTH-1:8]};
    end else begin : g_byte
        assign shifted = shift_byte_i;
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves data_d unassigned (no latch).
        data_d = data_q;
        if (load_i) begin
            data_d = load_data_i;
        end else if (shift_i) begin
            data_d = shifted;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/rv_bus_master.sv
// Bus master driven by a byte stream: 0x01 + N bytes issues a device write,
// 0x00 issues a device read whose data is returned LSB-first on TX.
module rv_bus_master
    import rv_pkg::*;
#(
    parameter int WRITE_WIDTH    = 32,
    parameter int READ_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic             CLK_I,
    input logic             RST_NI,
    rv_bus_master_if.master bus
);

    localparam int SH_W  = max_width(WRITE_WIDTH, READ_WIDTH);
    localparam int CNT_W = $clog2(SH_W / 8) + 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WRITE_WIDTH / 8 - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_WIDTH / 8 - 1);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic             error_q, error_d;
    logic             write_valid_q, write_valid_d;
    logic             read_ready_q, read_ready_d;
    logic             tx_valid_q, tx_valid_d;

    logic             rx_ready, rx_fire, to_expired;
    logic             sh_load, sh_shift;
    logic [7:0]       sh_byte;
    logic [SH_W-1:0]  sh_load_data, sh_data;

    // Gated by reset so the port reads 0 while held in reset and 1 as soon as it lifts.
    assign rx_ready   = RST_NI && (state_q == IDLE || state_q == RX_DATA);
    assign rx_fire    = bus.RX_VALID_I && rx_ready;
    assign to_expired = (to_q == TO_LAST);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        to_d         = to_q;
        error_d      = 1'b0;
        sh_load      = 1'b0;
        sh_shift     = 1'b0;
        sh_byte      = '0;
        sh_load_data = '0;
        sh_load_data[READ_WIDTH-1:0] = bus.READ_DATA_I;

        unique case (state_q)
            IDLE: begin
                if (rx_fire) begin
                    if (bus.RX_DATA_I == CMD_WRITE) begin
                        cnt_d   = '0;
                        state_d = RX_DATA;
                    end else if (bus.RX_DATA_I == CMD_READ) begin
                        to_d    = '0;
                        state_d = RD_REQ;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            RX_DATA: begin
                if (rx_fire) begin
                    sh_shift = 1'b1;
                    sh_byte  = bus.RX_DATA_I;
                    if (cnt_q == WR_LAST) begin
                        to_d    = '0;
                        state_d = WR_REQ;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            // A handshake in the expiry cycle still completes the request.
            WR_REQ: begin
                if (bus.WRITE_READY_I) begin
                    state_d = IDLE;
                end else if (to_expired) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            RD_REQ: begin
                if (bus.READ_VALID_I) begin
                    sh_load = 1'b1;
                    cnt_d   = '0;
                    state_d = TX_DATA;
                end else if (to_expired) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            TX_DATA: begin
                if (bus.TX_READY_I) begin
                    if (cnt_q == RD_LAST) begin
                        state_d = IDLE;
                    end else begin
                        sh_shift = 1'b1;
                        cnt_d    = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        write_valid_d = (state_d == WR_REQ);
        read_ready_d  = (state_d == RD_REQ);
        tx_valid_d    = (state_d == TX_DATA);
    end

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            to_q          <= '0;
            error_q       <= 1'b0;
            write_valid_q <= 1'b0;
            read_ready_q  <= 1'b0;
            tx_valid_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            to_q          <= to_d;
            error_q       <= error_d;
            write_valid_q <= write_valid_d;
            read_ready_q  <= read_ready_d;
            tx_valid_q    <= tx_valid_d;
        end
    end

    rv_byte_shifter #(
        .WIDTH (SH_W)
    ) u_shifter (
        .clk          (CLK_I),
        .rst_n        (RST_NI),
        .load_i       (sh_load),
        .load_data_i  (sh_load_data),
        .shift_i      (sh_shift),
        .shift_byte_i (sh_byte),
        .data_o       (sh_data)
    );

    // Write bytes land in the top of the shifter; read bytes leave from bit 0.
    assign bus.RX_READY_O    = rx_ready;
    assign bus.TX_VALID_O    = tx_valid_q;
    assign bus.TX_DATA_O     = sh_data[7:0];
    assign bus.READ_READY_O  = read_ready_q;
    assign bus.WRITE_VALID_O = write_valid_q;
    assign bus.WRITE_DATA_O  = sh_data[SH_W-1 -: WRITE_WIDTH];
    assign bus.ERROR_O       = error_q;

endmodule

// File: tb/tb_rv_bus_master.sv
// Self-checking bench for rv_bus_master (32-bit write, 16-bit read, timeout 8):
// directed transaction table, reset corner cases, then random transactions.
module tb_rv_bus_master;
    import rv_pkg::*;

    localparam int WW = 32;
    localparam int RW = 16;
    localparam int TO = 8;

    typedef enum logic [1:0] {K_WRITE, K_READ, K_ILLEGAL} kind_e;

    // delay: cycles the device holds its handshake low; stall: TX_READY_I low cycles per byte
    typedef struct {
        kind_e       kind;
        logic [31:0] data;
        int          delay;
        int          stall;
        logic        exp_err;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;

    rv_bus_master_if #(.WRITE_WIDTH(WW), .READ_WIDTH(RW)) bus ();

    rv_bus_master #(
        .WRITE_WIDTH    (WW),
        .READ_WIDTH     (RW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .CLK_I  (clk),
        .RST_NI (rst_n),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [63:0] outs();
        logic [63:0] r;
        r = 64'({bus.RX_READY_O, bus.TX_VALID_O, bus.TX_DATA_O, bus.READ_READY_O,
                 bus.WRITE_VALID_O, bus.WRITE_DATA_O, bus.ERROR_O});
        return r;
    endfunction

    // Reference rule: illegal commands always error; requests error when the
    // device does not answer within TO cycles of the request being raised.
    function automatic logic model_error(input vec_t v);
        if (v.kind == K_ILLEGAL) return 1'b1;
        return (v.delay >= TO);
    endfunction

    task automatic noise();
        bus.READ_VALID_I  = 1'($urandom);
        bus.WRITE_READY_I = 1'($urandom);
        bus.TX_READY_I    = 1'($urandom);
        bus.READ_DATA_I   = RW'($urandom);
    endtask

    task automatic quiet();
        bus.READ_VALID_I  = 1'b0;
        bus.WRITE_READY_I = 1'b0;
        bus.TX_READY_I    = 1'b0;
    endtask

    task automatic gap(input int n);
        for (int k = 0; k < n; k++) begin
            noise();
            @(negedge clk);
        end
        quiet();
    endtask

    // Called and returns at a negedge; returns in the cycle after acceptance.
    task automatic send_byte(input logic [7:0] b);
        bit done;
        done = 1'b0;
        bus.RX_VALID_I = 1'b1;
        bus.RX_DATA_I  = b;
        for (int k = 0; k < 20 && !done; k++) begin
            done = bus.RX_READY_O;
            noise();
            @(negedge clk);
        end
        bus.RX_VALID_I = 1'b0;
        quiet();
        if (!done) check("rx_accept_bound", 64'd0, 64'd1);
    endtask

    task automatic run_txn(input vec_t v);
        int n;
        n = (v.delay < TO) ? v.delay + 1 : TO;
        case (v.kind)
            K_ILLEGAL: begin
                send_byte(v.data[7:0]);
                check("illegal_err", 64'(bus.ERROR_O), 64'd1);
                check("illegal_idle", 64'(bus.RX_READY_O), 64'd1);
                @(negedge clk);
                check("illegal_err_end", 64'(bus.ERROR_O), 64'd0);
            end
            K_WRITE: begin
                send_byte(CMD_WRITE);
                check("wr_rx_ready", 64'(bus.RX_READY_O), 64'd1);
                for (int i = 0; i < WW / 8; i++) begin
                    gap(int'($urandom_range(0, 2)));
                    send_byte(v.data[8*i +: 8]);
                end
                for (int c = 0; c < n; c++) begin
                    check("wr_valid", 64'(bus.WRITE_VALID_O), 64'd1);
                    check("wr_data", 64'(bus.WRITE_DATA_O), 64'(v.data));
                    check("wr_no_rd_ready", 64'(bus.READ_READY_O), 64'd0);
                    check("wr_no_rx_ready", 64'(bus.RX_READY_O), 64'd0);
                    bus.WRITE_READY_I = (c == v.delay);
                    @(negedge clk);
                end
                bus.WRITE_READY_I = 1'b0;
                check("wr_valid_drop", 64'(bus.WRITE_VALID_O), 64'd0);
                check("wr_err", 64'(bus.ERROR_O), 64'(v.exp_err));
                check("wr_back_idle", 64'(bus.RX_READY_O), 64'd1);
                @(negedge clk);
                check("wr_err_end", 64'(bus.ERROR_O), 64'd0);
            end
            K_READ: begin
                send_byte(CMD_READ);
                for (int c = 0; c < n; c++) begin
                    check("rd_ready", 64'(bus.READ_READY_O), 64'd1);
                    check("rd_no_wr_valid", 64'(bus.WRITE_VALID_O), 64'd0);
                    check("rd_no_tx", 64'(bus.TX_VALID_O), 64'd0);
                    bus.READ_VALID_I = (c == v.delay);
                    bus.READ_DATA_I  = (c == v.delay) ? v.data[RW-1:0] : RW'($urandom);
                    @(negedge clk);
                end
                bus.READ_VALID_I = 1'b0;
                bus.READ_DATA_I  = RW'($urandom);
                check("rd_ready_drop", 64'(bus.READ_READY_O), 64'd0);
                check("rd_err", 64'(bus.ERROR_O), 64'(v.exp_err));
                if (v.exp_err) begin
                    check("rd_timeout_no_tx", 64'(bus.TX_VALID_O), 64'd0);
                    @(negedge clk);
                    check("rd_err_end", 64'(bus.ERROR_O), 64'd0);
                    check("rd_timeout_no_tx2", 64'(bus.TX_VALID_O), 64'd0);
                end else begin
                    for (int i = 0; i < RW / 8; i++) begin
                        for (int s = 0; s <= v.stall; s++) begin
                            check("tx_valid", 64'(bus.TX_VALID_O), 64'd1);
                            check("tx_data", 64'(bus.TX_DATA_O), 64'(v.data[8*i +: 8]));
                            check("tx_no_rx_ready", 64'(bus.RX_READY_O), 64'd0);
                            bus.TX_READY_I = (s == v.stall);
                            @(negedge clk);
                        end
                        bus.TX_READY_I = 1'b0;
                    end
                    check("tx_done", 64'(bus.TX_VALID_O), 64'd0);
                    check("tx_back_idle", 64'(bus.RX_READY_O), 64'd1);
                    check("tx_no_err", 64'(bus.ERROR_O), 64'd0);
                end
            end
            default: check("bad_kind", 64'd0, 64'd1);
        endcase
    endtask

    vec_t dir[11];
    vec_t rv;

    initial begin
        dir[0]  = '{K_WRITE,   32'h12345678, 2,  0, 1'b0};
        dir[1]  = '{K_READ,    32'h0000BEEF, 3,  0, 1'b0};
        dir[2]  = '{K_READ,    32'h00001111, 50, 0, 1'b1};
        dir[3]  = '{K_ILLEGAL, 32'h0000005A, 0,  0, 1'b1};
        dir[4]  = '{K_WRITE,   32'hA5A50FF0, 0,  0, 1'b0};
        dir[5]  = '{K_READ,    32'h00001234, 0,  5, 1'b0};
        dir[6]  = '{K_WRITE,   32'hDEADBEEF, 7,  0, 1'b0};
        dir[7]  = '{K_WRITE,   32'h01020304, 8,  0, 1'b1};
        dir[8]  = '{K_READ,    32'h0000C3A5, 7,  1, 1'b0};
        dir[9]  = '{K_READ,    32'h00007E81, 8,  0, 1'b1};
        dir[10] = '{K_ILLEGAL, 32'h000000FF, 0,  0, 1'b1};

        rst_n            = 1'b0;
        bus.RX_VALID_I   = 1'b0;
        bus.RX_DATA_I    = '0;
        bus.READ_DATA_I  = '0;
        quiet();
        repeat (2) @(negedge clk);
        check("reset_outputs", outs(), 64'd0);
        rst_n = 1'b1;
        #1;
        check("rx_ready_after_release", 64'(bus.RX_READY_O), 64'd1);
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            run_txn(dir[i]);
            gap(1);
        end

        // Reset in the middle of a write assembly, after two data bytes.
        send_byte(CMD_WRITE);
        send_byte(8'h11);
        send_byte(8'h22);
        #2 rst_n = 1'b0;
        #1 check("reset_mid_rx_outputs", outs(), 64'd0);
        @(negedge clk);
        check("reset_hold_outputs", outs(), 64'd0);
        rst_n = 1'b1;
        #1 check("release_rx_ready_only", outs(), 64'd1 << 44);
        @(negedge clk);
        rv = '{K_WRITE, 32'hCAFEF00D, 1, 0, 1'b0};
        run_txn(rv);

        // Reset while a read request is pending: no error, no response.
        send_byte(CMD_READ);
        check("rd_pending", 64'(bus.READ_READY_O), 64'd1);
        #2 rst_n = 1'b0;
        #1 check("reset_mid_rd_outputs", outs(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_reset_quiet", outs(), 64'd1 << 44);
        end

        for (int t = 0; t < 40; t++) begin
            rv.kind  = kind_e'($urandom_range(0, 2));
            rv.data  = $urandom;
            rv.delay = int'($urandom_range(0, TO + 2));
            rv.stall = int'($urandom_range(0, 3));
            if (rv.kind == K_ILLEGAL) rv.data = 32'($urandom_range(2, 255));
            rv.exp_err = model_error(rv);
            run_txn(rv);
            gap(int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
